// File: rtl/opll_bus_writer.sv
// opll_bus_writer: buffers OPLL register writes in a small FIFO and replays
// each one onto the chip pins as an address cycle followed by a data cycle,
// inserting the mandatory master-clock waits after each cycle.
module opll_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_PULSE   = 2,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic [7:0]                    din,
    output logic                          a0,
    output logic                          cs_n,
    output logic                          wr_n,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int MAXW = (ADDR_WAIT > DATA_WAIT)
                          ? ((ADDR_WAIT > WR_PULSE) ? ADDR_WAIT : WR_PULSE)
                          : ((DATA_WAIT > WR_PULSE) ? DATA_WAIT : WR_PULSE);
    localparam int CW   = $clog2(MAXW);

    localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] WP_M1   = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] AW_M1   = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0] DW_M1   = CW'(DATA_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_WAIT,
        D_SET,
        D_STB,
        D_WAIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  wcnt;
    logic [15:0]    hold;

    logic [15:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;

    logic           push;
    logic           pop;

    // Handshake and pop decisions all come from registered count/state so
    // req_ready never depends combinationally on req_valid.
    always_comb begin
        req_ready = (count != DEPTH_C);
        push      = req_valid && req_ready;
        pop       = (count != '0) &&
                    ((state == IDLE) || ((state == D_WAIT) && (wcnt == '0)));
    end

    assign fifo_count = count;

    // Request storage; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_addr, req_data};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus sequencer: pins are registered from the current state, so they trail
    // the state register by one cycle and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
            hold  <= '0;
            din   <= '0;
            a0    <= 1'b0;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state != IDLE) || (count != '0);
            done <= (state == D_WAIT) && (wcnt == '0);

            case (state)
                A_SET: begin
                    din  <= hold[15:8];
                    a0   <= 1'b0;
                    cs_n <= 1'b0;
                    wr_n <= 1'b1;
                end
                A_STB, D_STB: begin
                    cs_n <= 1'b0;
                    wr_n <= 1'b0;
                end
                A_WAIT: begin
                    cs_n <= (wcnt != AW_M1);
                    wr_n <= 1'b1;
                end
                D_SET: begin
                    din  <= hold[7:0];
                    a0   <= 1'b1;
                    cs_n <= 1'b0;
                    wr_n <= 1'b1;
                end
                D_WAIT: begin
                    cs_n <= (wcnt != DW_M1);
                    wr_n <= 1'b1;
                end
                default: begin
                    cs_n <= 1'b1;
                    wr_n <= 1'b1;
                end
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        hold  <= mem[rd_ptr];
                        state <= A_SET;
                    end
                end
                A_SET: begin
                    wcnt  <= WP_M1;
                    state <= A_STB;
                end
                A_STB: begin
                    if (wcnt == '0) begin
                        wcnt  <= AW_M1;
                        state <= A_WAIT;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                A_WAIT: begin
                    if (wcnt == '0) begin
                        state <= D_SET;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                D_SET: begin
                    wcnt  <= WP_M1;
                    state <= D_STB;
                end
                D_STB: begin
                    if (wcnt == '0) begin
                        wcnt  <= DW_M1;
                        state <= D_WAIT;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                D_WAIT: begin
                    if (wcnt == '0) begin
                        if (pop) begin
                            hold  <= mem[rd_ptr];
                            state <= A_SET;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
